serializer_stream: RTL and testbench

Parametrised successor to the fixed-length serializer. It accepts a parallel frame of up to NUM_WORDS words over a valid/ready handshake and emits it one word per accepted beat on a valid/ready output stream. Length and word order are selectable per frame at runtime, and o_last marks the final word. Frames stream back-to-back with zero bubble cycles. It sits between a parallel producer (register bank or packet builder) and a narrow link or FIFO.

---
 rtl/serializer_pkg.sv | 16 +
 rtl/serializer_stream.sv | 165 ++++++++++++++++
 tb/tb_serializer_stream.sv | 323 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/serializer_pkg.sv
// Shared definitions for the stream serializer/deserializer family.
// Provides the FSM state encodings and the index-width helper used to
// derive CNT_W from NUM_WORDS.
package serializer_pkg;

    localparam int unsigned STATE_W = 1;

    localparam logic [STATE_W-1:0] ST_IDLE = 1'b0;
    localparam logic [STATE_W-1:0] ST_SEND = 1'b1;

    // Width of a word index/length field; a single-word frame still needs one bit.
    function automatic int unsigned cnt_width(input int unsigned num_words);
        return (num_words > 1) ? $clog2(num_words) : 1;
    endfunction

endpackage

// File: rtl/serializer_stream.sv
// Parallel-to-serial stream converter.
// Accepts a frame of up to NUM_WORDS words of WIDTH bits over a valid/ready
// handshake and replays it one word per accepted beat, big- or little-endian,
// with a runtime-selectable length. Frames chain back to back with no bubble.
//
// Ports:
//   clk              rising-edge clock
//   i_reset_n        asynchronous active-low reset
//   i_data           parallel frame (word k = i_data[k*WIDTH +: WIDTH])
//   i_len_m1         frame length minus one (clamped to NUM_WORDS-1)
//   i_little_endian  1: word 0 first, 0: top word first
//   i_valid/o_ready  frame handshake (o_ready is combinational from i_ready)
//   o_data/o_valid   output word stream
//   o_last           marks the final word of a frame
//   i_ready          downstream beat acceptance
//   o_len_err        one-cycle pulse after accepting an out-of-range length
module serializer_stream
    import serializer_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned NUM_WORDS = 4,
    parameter int unsigned CNT_W     = cnt_width(NUM_WORDS)
) (
    input  logic                       clk,
    input  logic                       i_reset_n,
    input  logic [WIDTH*NUM_WORDS-1:0] i_data,
    input  logic [CNT_W-1:0]           i_len_m1,
    input  logic                       i_little_endian,
    input  logic                       i_valid,
    output logic                       o_ready,
    output logic [WIDTH-1:0]           o_data,
    output logic                       o_valid,
    output logic                       o_last,
    input  logic                       i_ready,
    output logic                       o_len_err
);

    localparam int unsigned FRAME_W = WIDTH * NUM_WORDS;
    localparam logic [CNT_W-1:0] MAX_IDX = CNT_W'(NUM_WORDS - 1);

    logic [STATE_W-1:0] state;
    logic [STATE_W-1:0] state_nxt;

    logic [FRAME_W-1:0] frame;
    logic [FRAME_W-1:0] frame_nxt;
    logic               frame_le;
    logic               frame_le_nxt;
    logic [CNT_W-1:0]   len_m1;
    logic [CNT_W-1:0]   len_m1_nxt;
    logic [CNT_W-1:0]   index;
    logic [CNT_W-1:0]   index_nxt;
    logic [CNT_W-1:0]   index_inc;
    logic [WIDTH-1:0]   data_nxt;
    logic               valid_nxt;
    logic               last_nxt;
    logic               len_err_nxt;

    logic               take;
    logic               last_take;
    logic               accept;
    logic               len_clamped;
    logic [CNT_W-1:0]   len_eff;

    // Beat k maps to slice k (LE) or NUM_WORDS-1-k (BE).
    function automatic logic [WIDTH-1:0] pick_word(
        input logic [FRAME_W-1:0] f,
        input logic               le,
        input logic [CNT_W-1:0]   k
    );
        logic [CNT_W-1:0] slice;
        slice = le ? k : (MAX_IDX - k);
        return f[slice*WIDTH +: WIDTH];
    endfunction

    // Handshake decode; a new frame may enter on the very beat that retires the last word.
    assign take        = o_valid && i_ready;
    assign last_take   = take && o_last;
    assign o_ready     = (state == ST_IDLE) || last_take;
    assign accept      = i_valid && o_ready;
    assign len_clamped = (32'(i_len_m1) > (32'(NUM_WORDS) - 32'd1));
    assign len_eff     = len_clamped ? MAX_IDX : i_len_m1;
    assign index_inc   = index + CNT_W'(1);

    // State register.
    always_ff @(posedge clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_nxt    = state;
        frame_nxt    = frame;
        frame_le_nxt = frame_le;
        len_m1_nxt   = len_m1;
        index_nxt    = index;
        data_nxt     = o_data;
        valid_nxt    = o_valid;
        last_nxt     = o_last;
        len_err_nxt  = 1'b0;

        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_nxt = ST_SEND;
                end
            end
            ST_SEND: begin
                if (last_take && !accept) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        if (accept) begin
            // Present beat 0 straight from the inputs so it appears one cycle after accept.
            frame_nxt    = i_data;
            frame_le_nxt = i_little_endian;
            len_m1_nxt   = len_eff;
            index_nxt    = '0;
            data_nxt     = pick_word(i_data, i_little_endian, '0);
            valid_nxt    = 1'b1;
            last_nxt     = (len_eff == '0);
            len_err_nxt  = len_clamped;
        end else if (last_take) begin
            // o_data deliberately keeps the final word.
            valid_nxt = 1'b0;
            last_nxt  = 1'b0;
        end else if (take) begin
            index_nxt = index_inc;
            data_nxt  = pick_word(frame, frame_le, index_inc);
            last_nxt  = (index_inc == len_m1);
        end
    end

    // Frame and output registers.
    always_ff @(posedge clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            frame     <= '0;
            frame_le  <= 1'b0;
            len_m1    <= '0;
            index     <= '0;
            o_data    <= '0;
            o_valid   <= 1'b0;
            o_last    <= 1'b0;
            o_len_err <= 1'b0;
        end else begin
            frame     <= frame_nxt;
            frame_le  <= frame_le_nxt;
            len_m1    <= len_m1_nxt;
            index     <= index_nxt;
            o_data    <= data_nxt;
            o_valid   <= valid_nxt;
            o_last    <= last_nxt;
            o_len_err <= len_err_nxt;
        end
    end

endmodule

// File: tb/tb_serializer_stream.sv
// Self-checking bench for serializer_stream: a scoreboard predicts every beat
// of the default 4x8 instance, and scenario tasks check latency, stalls,
// back-to-back chaining, async reset, and length clamping on a 3-word instance.
module tb_serializer_stream;

    localparam int unsigned W  = 8;
    localparam int unsigned NW = 4;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        i_reset_n;
    logic [31:0] i_data;
    logic [1:0]  i_len_m1;
    logic        i_little_endian;
    logic        i_valid;
    logic        o_ready;
    logic [7:0]  o_data;
    logic        o_valid;
    logic        o_last;
    logic        i_ready;
    logic        o_len_err;

    logic [23:0] c_data;
    logic [1:0]  c_len;
    logic        c_le;
    logic        c_valid;
    logic        c_ready;
    logic [7:0]  c_odata;
    logic        c_ovalid;
    logic        c_olast;
    logic        c_iready;
    logic        c_len_err;

    int checks   = 0;
    int failures = 0;

    logic [8:0] sb[$];

    serializer_stream #(.WIDTH(8), .NUM_WORDS(4)) dut (
        .clk(clk), .i_reset_n(i_reset_n), .i_data(i_data), .i_len_m1(i_len_m1),
        .i_little_endian(i_little_endian), .i_valid(i_valid), .o_ready(o_ready),
        .o_data(o_data), .o_valid(o_valid), .o_last(o_last), .i_ready(i_ready),
        .o_len_err(o_len_err)
    );

    serializer_stream #(.WIDTH(8), .NUM_WORDS(3)) dut3 (
        .clk(clk), .i_reset_n(i_reset_n), .i_data(c_data), .i_len_m1(c_len),
        .i_little_endian(c_le), .i_valid(c_valid), .o_ready(c_ready),
        .o_data(c_odata), .o_valid(c_ovalid), .o_last(c_olast), .i_ready(c_iready),
        .o_len_err(c_len_err)
    );

    // Scoreboard: pop/compare transferred beats, then push predictions for an accepted frame.
    always @(negedge clk) begin : scoreboard
        logic [8:0]  exp;
        logic [31:0] sh;
        int          eff;
        int          s;
        if (o_valid && i_ready) begin
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL sb_unexpected_beat: got last=%b data=%h, required no beat", o_last, o_data);
            end else begin
                exp = sb.pop_front();
                if ({o_last, o_data} !== exp) begin
                    failures++;
                    $display("FAIL sb_beat: got last=%b data=%h, required last=%b data=%h",
                             o_last, o_data, exp[8], exp[7:0]);
                end
            end
        end
        if (i_reset_n && i_valid && o_ready) begin
            eff = (int'(i_len_m1) > NW - 1) ? NW - 1 : int'(i_len_m1);
            for (int k = 0; k <= eff; k++) begin
                s  = i_little_endian ? k : NW - 1 - k;
                sh = i_data >> (s * W);
                sb.push_back({(k == eff), sh[7:0]});
            end
        end
    end

    // Offer one frame, wait (bounded) for acceptance, then scramble the inputs.
    task automatic drive_frame(input logic [31:0] d, input logic [1:0] len, input logic le);
        logic got;
        got = 1'b0;
        @(posedge clk) #1;
        i_data = d; i_len_m1 = len; i_little_endian = le; i_valid = 1'b1;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (o_ready) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            checks++; failures++;
            $display("FAIL accept_timeout: got o_ready=0 for 50 cycles, required 1");
        end
        @(posedge clk) #1;
        i_valid = 1'b0; i_data = 32'hdeadbeef; i_len_m1 = 2'd0; i_little_endian = ~le;
    endtask

    // Count valid cycles until the stream drains (bounded).
    task automatic wait_idle(output int nvalid);
        logic done;
        done   = 1'b0;
        nvalid = 0;
        for (int n = 0; n < 100 && !done; n++) begin
            @(negedge clk);
            if (o_valid) nvalid++;
            else if (sb.size() == 0) done = 1'b1;
        end
        if (!done) begin
            checks++; failures++;
            $display("FAIL drain_timeout: got stream still busy, required idle within 100 cycles");
        end
    endtask

    task automatic test_reset;
        i_reset_n = 1'b0; i_data = '0; i_len_m1 = '0; i_little_endian = 1'b0;
        i_valid = 1'b0; i_ready = 1'b1;
        c_data = '0; c_len = '0; c_le = 1'b0; c_valid = 1'b0; c_iready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({o_valid, o_last, o_data, o_len_err, o_ready} !== {1'b0, 1'b0, 8'h00, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL reset_values: got v=%b l=%b d=%h e=%b r=%b, required v=0 l=0 d=00 e=0 r=1",
                     o_valid, o_last, o_data, o_len_err, o_ready);
        end
        @(posedge clk) #1;
        i_reset_n = 1'b1;
    endtask

    task automatic test_frame(input logic [31:0] d, input logic [1:0] len, input logic le,
                              input logic [7:0] first, input logic [7:0] final_word);
        int n;
        drive_frame(d, len, le);
        @(negedge clk);
        checks++;
        if ({o_valid, o_last, o_data} !== {1'b1, (len == 2'd0), first}) begin
            failures++;
            $display("FAIL first_beat_latency: got v=%b l=%b d=%h, required v=1 l=%b d=%h",
                     o_valid, o_last, o_data, (len == 2'd0), first);
        end
        wait_idle(n);
        checks++;
        if (n + 1 !== int'(len) + 1) begin
            failures++;
            $display("FAIL beat_count: got %0d valid cycles, required %0d", n + 1, int'(len) + 1);
        end
        checks++;
        if ({o_valid, o_last, o_data} !== {1'b0, 1'b0, final_word}) begin
            failures++;
            $display("FAIL idle_hold: got v=%b l=%b d=%h, required v=0 l=0 d=%h",
                     o_valid, o_last, o_data, final_word);
        end
    endtask

    task automatic test_stall;
        int n;
        drive_frame(32'h12345678, 2'd3, 1'b0);
        @(posedge clk) #1;
        i_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({o_valid, o_last, o_data, o_ready} !== {1'b1, 1'b0, 8'h34, 1'b0}) begin
                failures++;
                $display("FAIL stall_hold[%0d]: got v=%b l=%b d=%h r=%b, required v=1 l=0 d=34 r=0",
                         i, o_valid, o_last, o_data, o_ready);
            end
        end
        @(posedge clk) #1;
        i_ready = 1'b1;
        wait_idle(n);
    endtask

    task automatic test_back_to_back;
        int nvalid;
        nvalid = 0;
        @(posedge clk) #1;
        i_data = 32'h12345678; i_len_m1 = 2'd3; i_little_endian = 1'b0; i_valid = 1'b1;
        @(negedge clk);
        checks++;
        if (o_ready !== 1'b1) begin
            failures++;
            $display("FAIL b2b_first_ready: got %b, required 1", o_ready);
        end
        @(posedge clk) #1;
        i_data = 32'h9abcdef0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (o_valid) nvalid++;
            if (i == 3) begin
                checks++;
                if (o_ready !== 1'b1) begin
                    failures++;
                    $display("FAIL b2b_ready_on_last: got %b, required 1", o_ready);
                end
            end
            @(posedge clk) #1;
            if (i == 3) i_valid = 1'b0;
        end
        checks++;
        if (nvalid !== 8) begin
            failures++;
            $display("FAIL b2b_continuous: got %0d valid cycles, required 8", nvalid);
        end
        @(negedge clk);
        checks++;
        if (o_valid !== 1'b0) begin
            failures++;
            $display("FAIL b2b_end: got o_valid=%b, required 0", o_valid);
        end
    endtask

    task automatic test_clamp;
        logic [7:0] be_words[3];
        logic [7:0] le_words[2];
        be_words = '{8'hAA, 8'hBB, 8'hCC};
        le_words = '{8'hCC, 8'hBB};
        @(posedge clk) #1;
        c_data = 24'hAABBCC; c_len = 2'd3; c_le = 1'b0; c_valid = 1'b1;
        @(negedge clk);
        checks++;
        if (c_ready !== 1'b1) begin
            failures++;
            $display("FAIL clamp_ready: got %b, required 1", c_ready);
        end
        @(posedge clk) #1;
        c_valid = 1'b0; c_data = '0; c_len = '0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({c_len_err, c_ovalid, c_olast, c_odata} !== {(i == 0), 1'b1, (i == 2), be_words[i]}) begin
                failures++;
                $display("FAIL clamp_beat[%0d]: got e=%b v=%b l=%b d=%h, required e=%b v=1 l=%b d=%h",
                         i, c_len_err, c_ovalid, c_olast, c_odata, (i == 0), (i == 2), be_words[i]);
            end
        end
        @(negedge clk);
        checks++;
        if ({c_ovalid, c_len_err} !== 2'b00) begin
            failures++;
            $display("FAIL clamp_end: got v=%b e=%b, required v=0 e=0", c_ovalid, c_len_err);
        end
        @(posedge clk) #1;
        c_data = 24'hAABBCC; c_len = 2'd1; c_le = 1'b1; c_valid = 1'b1;
        @(posedge clk) #1;
        c_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if ({c_len_err, c_ovalid, c_olast, c_odata} !== {1'b0, 1'b1, (i == 1), le_words[i]}) begin
                failures++;
                $display("FAIL short_le3_beat[%0d]: got e=%b v=%b l=%b d=%h, required e=0 v=1 l=%b d=%h",
                         i, c_len_err, c_ovalid, c_olast, c_odata, (i == 1), le_words[i]);
            end
        end
    endtask

    task automatic test_async_reset;
        int n;
        drive_frame(32'h12345678, 2'd3, 1'b0);
        @(negedge clk);
        @(posedge clk) #3;
        i_reset_n = 1'b0;
        #1;
        checks++;
        if ({o_valid, o_last, o_data} !== {1'b0, 1'b0, 8'h00}) begin
            failures++;
            $display("FAIL async_reset: got v=%b l=%b d=%h, required v=0 l=0 d=00", o_valid, o_last, o_data);
        end
        sb.delete();
        @(posedge clk) #1;
        i_reset_n = 1'b1;
        @(negedge clk);
        checks++;
        if (o_ready !== 1'b1) begin
            failures++;
            $display("FAIL post_reset_ready: got %b, required 1", o_ready);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (o_valid !== 1'b0) begin
                failures++;
                $display("FAIL post_reset_quiet[%0d]: got o_valid=%b, required 0", i, o_valid);
            end
        end
        drive_frame(32'h12345678, 2'd0, 1'b1);
        @(negedge clk);
        checks++;
        if ({o_valid, o_last, o_data} !== {1'b1, 1'b1, 8'h78}) begin
            failures++;
            $display("FAIL single_beat: got v=%b l=%b d=%h, required v=1 l=1 d=78", o_valid, o_last, o_data);
        end
        wait_idle(n);
    endtask

    initial begin
        test_reset();
        test_frame(32'h12345678, 2'd3, 1'b0, 8'h12, 8'h78);
        test_frame(32'h12345678, 2'd3, 1'b1, 8'h78, 8'h12);
        test_frame(32'h12345678, 2'd1, 1'b0, 8'h12, 8'h34);
        test_frame(32'h12345678, 2'd1, 1'b1, 8'h78, 8'h56);
        test_stall();
        test_back_to_back();
        test_clamp();
        test_async_reset();
        checks++;
        if (sb.size() !== 0) begin
            failures++;
            $display("FAIL sb_leftover: got %0d pending beats, required 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
